// File: rtl/result_store.sv
// Rescales and saturates signed accumulator values and writes them to consecutive memory words.
// Each accepted value is written one cycle later. STOP rises one cycle after the last write and holds until enable drops.
module result_store #(
  parameter int SIZE             = 11,
  parameter int SIZE_2           = 23,
  parameter int SIZE_address_pix = 13,
  parameter int NUM_OUT          = 11,
  parameter int SHIFT            = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic        [SIZE_address_pix-1:0] memstartp,
  input  logic                              in_valid,
  input  logic signed [SIZE_2-1:0]           in_data,
  output logic                              in_ready,
  output logic                              we,
  output logic        [SIZE_address_pix-1:0] write_addressp,
  output logic signed [SIZE-1:0]             dp,
  output logic                              STOP
);

  localparam int IW = $clog2(NUM_OUT + 1);
  localparam logic signed [SIZE_2-1:0] SAT_MAX = SIZE_2'((1 << (SIZE - 1)) - 1);
  localparam logic signed [SIZE_2-1:0] SAT_MIN = SIZE_2'(-(1 << (SIZE - 1)));

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                   state;
  logic [IW-1:0]            index;
  logic signed [SIZE_2-1:0] shifted;
  logic signed [SIZE-1:0]   sat_val;
  logic                     accept;

  // Arithmetic shift floors toward minus infinity before clamping.
  assign shifted = in_data >>> SHIFT;

  always_comb begin
    sat_val = shifted[SIZE-1:0];
    if (shifted > SAT_MAX)
      sat_val = SAT_MAX[SIZE-1:0];
    else if (shifted < SAT_MIN)
      sat_val = SAT_MIN[SIZE-1:0];
  end

  assign in_ready = enable & (state == RUN) & ~rst;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      index          <= '0;
      we             <= 1'b0;
      write_addressp <= '0;
      dp             <= '0;
      STOP           <= 1'b0;
    end else if (!enable) begin
      state <= IDLE;
      index <= '0;
      we    <= 1'b0;
      STOP  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= RUN;
          we    <= 1'b0;
        end
        RUN: begin
          we <= accept;
          if (accept) begin
            write_addressp <= memstartp + SIZE_address_pix'(index);
            dp             <= sat_val;
            index          <= index + 1'b1;
            if (index == IW'(NUM_OUT - 1))
              state <= FLUSH;
          end
        end
        FLUSH: begin
          state <= DONE;
          we    <= 1'b0;
          STOP  <= 1'b1;
        end
        DONE: begin
          we   <= 1'b0;
          STOP <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_store.sv
// Scoreboard bench for result_store: predicted writes are queued at accept and compared when we is seen.
module tb_result_store;
  localparam int SIZE    = 11;
  localparam int SIZE_2  = 23;
  localparam int AW      = 13;
  localparam int NUM_OUT = 11;
  localparam int SHIFT   = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   enable;
  logic [AW-1:0]          memstartp;
  logic                   in_valid;
  logic signed [SIZE_2-1:0] in_data;
  logic                   in_ready;
  logic                   we;
  logic [AW-1:0]          write_addressp;
  logic signed [SIZE-1:0] dp;
  logic                   STOP;

  result_store #(.SIZE(SIZE), .SIZE_2(SIZE_2), .SIZE_address_pix(AW),
                 .NUM_OUT(NUM_OUT), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .memstartp(memstartp),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .we(we), .write_addressp(write_addressp), .dp(dp), .STOP(STOP)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int dat; } wr_t;
  wr_t q[$];
  int  vals[$];
  int  checks = 0;
  int  errors = 0;
  int  m_idx = 0;
  int  cyc = 0;
  int  last_we = 0;
  int  wr_cnt = 0;
  bit  stop_q = 1'b0;
  int  pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model(input int v);
    int d = 1 << SHIFT;
    int r = v / d;
    if (v < 0 && (v % d) != 0) r = r - 1;
    if (r > (1 << (SIZE - 1)) - 1) r = (1 << (SIZE - 1)) - 1;
    if (r < -(1 << (SIZE - 1))) r = -(1 << (SIZE - 1));
    return r;
  endfunction

  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (we) begin
      if (q.size() == 0) chk("unexpected_we", 1, 0);
      else begin
        e = q.pop_front();
        chk("addr", int'(write_addressp), e.addr);
        chk("dp", int'(dp), e.dat);
      end
      last_we = cyc;
      wr_cnt++;
    end
    if (STOP && !stop_q) begin
      chk("stop_gap", cyc - last_we, 1);
      chk("stop_count", wr_cnt, NUM_OUT);
    end
    stop_q = STOP;
    if (rst || !enable) begin
      m_idx  = 0;
      wr_cnt = 0;
    end else if (in_valid && in_ready) begin
      e.addr = (int'(memstartp) + m_idx) % (1 << AW);
      e.dat  = model(int'(in_data));
      q.push_back(e);
      m_idx++;
    end
  end

  task automatic run_values(input int n, input int mode);
    int k = 0;
    int c = 0;
    while (k < n && c < 300) begin
      @(posedge clk); #1;
      in_valid = (mode == 0) ? 1'b1 : pat[c % 7][0];
      in_data  = SIZE_2'(vals[k]);
      #1;
      if (in_valid && in_ready) k++;
      c++;
    end
    if (k < n) chk("accept_timeout", k, n);
  endtask

  task automatic wait_stop();
    int c = 0;
    while (!STOP && c < 30) begin
      @(posedge clk); #2;
      c++;
    end
    if (!STOP) chk("stop_timeout", 0, 1);
  endtask

  task automatic set_nominal();
    vals.delete();
    for (int k = 0; k < NUM_OUT; k++) vals.push_back(k * 256);
  endtask

  task automatic restart();
    @(posedge clk); #1;
    enable   = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; memstartp = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_we", int'(we), 0);
    chk("rst_addr", int'(write_addressp), 0);
    chk("rst_dp", int'(dp), 0);
    chk("rst_stop", int'(STOP), 0);
    chk("rst_ready", int'(in_ready), 0);
    rst = 1'b0;

    // Nominal run, then overrun while DONE.
    memstartp = 13'd100;
    set_nominal();
    enable = 1'b1;
    run_values(NUM_OUT, 0);
    @(posedge clk); #2;
    chk("ready_after_last", int'(in_ready), 0);
    wait_stop();
    repeat (5) begin
      @(posedge clk); #2;
      chk("overrun_ready", int'(in_ready), 0);
      chk("overrun_stop", int'(STOP), 1);
    end
    enable = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("stop_clear", int'(STOP), 0);

    // Bubbles.
    enable = 1'b1;
    run_values(NUM_OUT, 1);
    wait_stop();

    // Saturation and rounding.
    vals.delete();
    vals.push_back(32'h3FFFFF);
    vals.push_back(-4194304);
    vals.push_back(-300);
    vals.push_back(300);
    vals.push_back(255);
    vals.push_back(-1);
    while (vals.size() < NUM_OUT)
      vals.push_back(int'($urandom_range(0, (1 << SIZE_2) - 1)) - (1 << (SIZE_2 - 1)));
    restart();
    run_values(NUM_OUT, 0);
    wait_stop();

    // Abort after 6 accepts, then a wrapping run.
    set_nominal();
    restart();
    run_values(6, 0);
    @(posedge clk); #1;
    enable = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("abort_we", int'(we), 0);
    chk("abort_stop", int'(STOP), 0);
    memstartp = 13'd8189;
    enable = 1'b1;
    run_values(NUM_OUT, 0);
    wait_stop();

    // Reset mid-run at index 4.
    memstartp = 13'd100;
    restart();
    run_values(4, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_we", int'(we), 0);
    chk("rst_mid_addr", int'(write_addressp), 0);
    chk("rst_mid_dp", int'(dp), 0);
    chk("rst_mid_stop", int'(STOP), 0);
    run_values(NUM_OUT, 0);
    wait_stop();

    repeat (3) @(posedge clk);
    #2;
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
